prog_loader: RTL and testbench

- Parametrised program-loading engine for the pipelined processor top level.
- Accepts a valid/ready stream of instruction words and address-set commands, and writes them into instruction memory.
- Holds the CPU in reset during loading and for a programmable hold period afterwards, then releases it and flags done.
- Replaces hand-driven writeInstruction/address sequencing with a reusable, restartable block.

---
 rtl/prog_loader.sv | 110 +++++++++++
 tb/tb_prog_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: streams instruction words and address-set commands into
// instruction memory while holding the core in reset, then releases it after
// a programmable hold period. Restartable from RUN with a new start pulse.
module prog_loader #(
  parameter int INSTR_W   = 16,
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 1,
  parameter int RST_HOLD  = 2,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               s_valid,
  input  logic [INSTR_W-1:0] s_data,
  input  logic               s_is_addr,
  input  logic               s_last,
  output logic               s_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   word_count
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   ptr;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [ADDR_W-1:0]   addr_ext;
  logic                hs;
  logic                restart;

  // Address commands narrower than the memory address are zero-extended,
  // wider ones are truncated to the low address bits.
  if (INSTR_W >= ADDR_W) begin : g_trunc
    assign addr_ext = s_data[ADDR_W-1:0];
  end else begin : g_zext
    assign addr_ext = {{(ADDR_W-INSTR_W){1'b0}}, s_data};
  end

  assign hs      = s_valid & s_ready;
  assign restart = start & ((state == IDLE) | (state == RUN));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; start is ignored while LOAD/HOLD are in progress
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start)                 state_nx = LOAD;
      LOAD: if (hs && s_last)          state_nx = HOLD;
      HOLD: if (hold_cnt == HOLD_W'(1)) state_nx = RUN;
      RUN:  if (start)                 state_nx = LOAD;
      default:                         state_nx = IDLE;
    endcase
  end

  // State-decoded control outputs
  always_comb begin
    s_ready = (state == LOAD);
    busy    = (state == LOAD) | (state == HOLD);
    done    = (state == RUN);
    cpu_rst = (state != RUN);
  end

  // Write pipeline, pointer, word counter and hold timer. A data handshake
  // produces the memory write one cycle later; reset drops a queued write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ptr        <= '0;
      word_count <= '0;
      hold_cnt   <= '0;
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        ptr        <= '0;
        word_count <= '0;
      end
      if (hs) begin
        if (s_is_addr) begin
          ptr <= addr_ext;
        end else begin
          mem_we    <= 1'b1;
          mem_addr  <= ptr;
          mem_wdata <= s_data;
          ptr       <= ptr + STEP;
          if (word_count != '1) word_count <= word_count + CNT_W'(1);
        end
      end
      if (hs && s_last)        hold_cnt <= HOLD_INIT;
      else if (state == HOLD)  hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (32-bit and 4-bit address) share one
// directed stimulus stream; a behavioural model predicts every output cycle
// by cycle, and literal write lists pin the model for each scenario.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_is_addr, s_last;
  logic [15:0] s_data;

  logic        a_s_ready, a_mem_we, a_cpu_rst, a_busy, a_done;
  logic [31:0] a_mem_addr;
  logic [15:0] a_mem_wdata, a_word_count;
  logic        b_s_ready, b_mem_we, b_cpu_rst, b_busy, b_done;
  logic [3:0]  b_mem_addr;
  logic [15:0] b_mem_wdata, b_word_count;

  always #5 clk = ~clk;

  prog_loader #(.INSTR_W(16), .ADDR_W(32), .ADDR_STEP(1), .RST_HOLD(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_is_addr(s_is_addr), .s_last(s_last), .s_ready(a_s_ready), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .cpu_rst(a_cpu_rst),
    .busy(a_busy), .done(a_done), .word_count(a_word_count));

  prog_loader #(.INSTR_W(16), .ADDR_W(4), .ADDR_STEP(1), .RST_HOLD(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_is_addr(s_is_addr), .s_last(s_last), .s_ready(b_s_ready), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .cpu_rst(b_cpu_rst),
    .busy(b_busy), .done(b_done), .word_count(b_word_count));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_LOAD = 1, P_HOLD = 2, P_RUN = 3;
  int          ph = P_IDLE;
  int          m_cnt = 0;
  int          m_hold = 0;
  logic        m_we = 1'b0;
  logic [15:0] m_wdata = '0;
  logic [31:0] m_ptr  [2];
  logic [31:0] m_addr [2];
  bit          live = 1'b0;

  function automatic logic [31:0] msk(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  // Predict what the outputs must show during the cycle after this edge.
  always @(posedge clk) begin
    live = 1'b1;
    if (rst) begin
      ph = P_IDLE; m_we = 1'b0; m_wdata = '0; m_cnt = 0; m_hold = 0;
      for (int k = 0; k < 2; k++) begin m_ptr[k] = '0; m_addr[k] = '0; end
    end else begin
      m_we = 1'b0;
      case (ph)
        P_IDLE, P_RUN: if (start) begin
          ph = P_LOAD; m_cnt = 0;
          for (int k = 0; k < 2; k++) m_ptr[k] = '0;
        end
        P_LOAD: if (s_valid) begin
          if (s_is_addr) begin
            for (int k = 0; k < 2; k++) m_ptr[k] = {16'h0, s_data} & msk(k);
          end else begin
            m_we = 1'b1; m_wdata = s_data;
            for (int k = 0; k < 2; k++) begin
              m_addr[k] = m_ptr[k];
              m_ptr[k]  = (m_ptr[k] + 32'd1) & msk(k);
            end
            if (m_cnt < 65535) m_cnt++;
          end
          if (s_last) begin ph = P_HOLD; m_hold = 2; end
        end
        P_HOLD: begin
          m_hold--;
          if (m_hold == 0) ph = P_RUN;
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  // Observed writes, for the literal per-scenario checks.
  logic [31:0] wa_q [$];
  logic [15:0] wd_q [$];
  logic [3:0]  wb_q [$];

  // Compare every cycle, mid-way between edges.
  always @(negedge clk) begin
    if (live) begin
      chk("a.cpu_rst", a_cpu_rst, ph != P_RUN);
      chk("a.s_ready", a_s_ready, ph == P_LOAD);
      chk("a.busy",    a_busy,    (ph == P_LOAD) || (ph == P_HOLD));
      chk("a.done",    a_done,    ph == P_RUN);
      chk("a.mem_we",  a_mem_we,  m_we);
      chk("a.mem_addr", a_mem_addr, m_addr[0]);
      chk("a.mem_wdata", a_mem_wdata, m_wdata);
      chk("a.word_count", a_word_count, m_cnt);
      chk("b.cpu_rst", b_cpu_rst, ph != P_RUN);
      chk("b.s_ready", b_s_ready, ph == P_LOAD);
      chk("b.mem_we",  b_mem_we,  m_we);
      chk("b.mem_addr", b_mem_addr, m_addr[1]);
      chk("b.word_count", b_word_count, m_cnt);
      if (a_mem_we) begin wa_q.push_back(a_mem_addr); wd_q.push_back(a_mem_wdata); end
      if (b_mem_we) wb_q.push_back(b_mem_addr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic clr_log();
    wa_q.delete(); wd_q.delete(); wb_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Present one word; during gap cycles the word is held with s_valid low
  // and a stray start pulse is driven (must be ignored while loading).
  task automatic send(input logic [15:0] d, input logic is_a, input logic lst, input int gap);
    bit hs;
    s_data = d; s_is_addr = is_a; s_last = lst;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
    end
    s_valid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk); hs = a_s_ready;
      tick();
    end
    if (!hs) begin n_cmp++; n_bad++; $display("FAIL handshake_timeout: got no ready want ready"); end
    s_valid = 1'b0; s_last = 1'b0; s_is_addr = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (a_done) ok = 1'b1; else tick();
    end
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL done_timeout: got done=0 want done=1"); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_is_addr = 1'b0; s_last = 1'b0;
    repeat (3) tick();
    chk("rst.cpu_rst", a_cpu_rst, 1);
    chk("rst.s_ready", a_s_ready, 0);
    chk("rst.mem_we", a_mem_we, 0);
    chk("rst.word_count", a_word_count, 0);
    rst = 1'b0;

    // stray valid in IDLE: no side effects
    s_valid = 1'b1; s_data = 16'hDEAD; tick(); tick(); s_valid = 1'b0;

    // basic load of three words
    clr_log(); pulse_start();
    send(16'h1C00, 0, 0, 0); send(16'h0C00, 0, 0, 0); send(16'h3E40, 0, 1, 0);
    wait_done();
    chk("t1.nwr", wa_q.size(), 3);
    chk("t1.a0", wa_q[0], 32'h0); chk("t1.d0", wd_q[0], 16'h1C00);
    chk("t1.a1", wa_q[1], 32'h1); chk("t1.d1", wd_q[1], 16'h0C00);
    chk("t1.a2", wa_q[2], 32'h2); chk("t1.d2", wd_q[2], 16'h3E40);
    chk("t1.count", a_word_count, 3);
    chk("t1.cpu_rst", a_cpu_rst, 0);

    // address-set commands, restart from RUN
    clr_log(); pulse_start();
    send(16'h0020, 1, 0, 0); send(16'h4811, 0, 0, 0); send(16'h000A, 0, 0, 0);
    send(16'h0005, 1, 0, 0); send(16'h0058, 0, 1, 0);
    wait_done();
    chk("t2.nwr", wa_q.size(), 3);
    chk("t2.a0", wa_q[0], 32'h20); chk("t2.a1", wa_q[1], 32'h21); chk("t2.a2", wa_q[2], 32'h05);
    chk("t2.d2", wd_q[2], 16'h0058);
    chk("t2.b1", wb_q[1], 4'h1);
    chk("t2.count", a_word_count, 3);

    // gapped source with stray starts while loading
    clr_log(); pulse_start();
    send(16'h0001, 0, 0, 1); send(16'h0002, 0, 0, 1);
    send(16'h0003, 0, 0, 1); send(16'h0004, 0, 1, 1);
    wait_done();
    chk("t3.nwr", wa_q.size(), 4);
    chk("t3.a0", wa_q[0], 0); chk("t3.a1", wa_q[1], 1);
    chk("t3.a2", wa_q[2], 2); chk("t3.a3", wa_q[3], 3);
    chk("t3.d3", wd_q[3], 16'h0004);

    // pointer wrap on the 4-bit instance
    clr_log(); pulse_start();
    send(16'h000F, 1, 0, 0); send(16'hAAA1, 0, 0, 0);
    send(16'hAAA2, 0, 0, 0); send(16'hAAA3, 0, 1, 0);
    wait_done();
    chk("t4.nwr", wb_q.size(), 3);
    chk("t4.b0", wb_q[0], 4'hF); chk("t4.b1", wb_q[1], 4'h0); chk("t4.b2", wb_q[2], 4'h1);
    chk("t4.a1", wa_q[1], 32'h10);

    // reset mid-load, coinciding with a handshake (queued write dropped)
    clr_log(); pulse_start();
    send(16'h1111, 0, 0, 0); send(16'h2222, 0, 0, 0);
    s_valid = 1'b1; s_data = 16'h3333; rst = 1'b1; tick();
    chk("t5.mem_we", a_mem_we, 0);
    chk("t5.cpu_rst", a_cpu_rst, 1);
    chk("t5.busy", a_busy, 0);
    chk("t5.count", a_word_count, 0);
    chk("t5.addr", a_mem_addr, 0);
    start = 1'b1; tick(); start = 1'b0; rst = 1'b0; s_valid = 1'b0;
    chk("t5.rst_wins", a_s_ready, 0);
    chk("t5.nwr_pre", wa_q.size(), 2);
    clr_log(); pulse_start();
    send(16'h5555, 0, 0, 0); send(16'h6666, 0, 1, 0);
    wait_done();
    chk("t5.nwr", wa_q.size(), 2);
    chk("t5.a0", wa_q[0], 0); chk("t5.a1", wa_q[1], 1);
    chk("t5.count2", a_word_count, 2);

    // restart with only an address word
    clr_log(); pulse_start();
    chk("t6.cpu_rst", a_cpu_rst, 1);
    send(16'h0010, 1, 1, 0);
    wait_done();
    chk("t6.nwr", wa_q.size(), 0);
    chk("t6.count", a_word_count, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
